// File: rtl/edge_stream_3x3.sv
// edge_stream_3x3: streaming 3x3 edge operator for RGB camera pixels.
// Builds a 3x3 grayscale window from two internal line buffers and emits one
// edge pixel per accepted input pixel, exactly three clocks later.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   in_valid, in_sof  input strobe (no backpressure), start-of-frame marker
//   in_pixel          {R,G,B}, PIX_BITS each
//   mode, gain,       operator select, saturating left shift, threshold;
//   thresh            captured on the in_sof pixel and held for the frame
//   out_valid,        output strobe, start-of-frame marker
//   out_sof
//   out_pixel         result replicated on all three channels
//   out_border        window incomplete, out_pixel forced to 0
module edge_stream_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int PIX_BITS  = 4,
    parameter int COL_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [3*PIX_BITS-1:0] in_pixel,
    input  logic [1:0]            mode,
    input  logic [1:0]            gain,
    input  logic [PIX_BITS-1:0]   thresh,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic [3*PIX_BITS-1:0] out_pixel,
    output logic                  out_border
);
    localparam int PW = PIX_BITS;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Left shift by 0..3 with saturation to all-ones instead of wrapping.
    function automatic logic [PW-1:0] sat_gain(input logic [PW-1:0] g, input logic [1:0] sh);
        logic [PW+2:0] wide;
        wide = {3'b000, g} << sh;
        return (|wide[PW+2:PW]) ? '1 : wide[PW-1:0];
    endfunction

    // Frame position of the next pixel and frame-stable configuration.
    logic [COL_BITS-1:0] col_q;
    logic [1:0]          row_q;
    logic [1:0]          mode_q, gain_q;
    logic [PW-1:0]       thresh_q;

    logic [PW+1:0]       rgb_sum;
    logic [PW-1:0]       gray_d;
    logic [COL_BITS-1:0] pix_col;
    logic [1:0]          pix_row;

    assign rgb_sum = {2'b00, in_pixel[3*PW-1:2*PW]} + {2'b00, in_pixel[2*PW-1:PW]}
                   + {2'b00, in_pixel[PW-1:0]};
    assign gray_d  = PW'(rgb_sum / (PW+2)'(3));
    assign pix_col = in_sof ? '0 : col_q;
    assign pix_row = in_sof ? '0 : row_q;

    logic                vld_p0_q, sof_p0_q;
    logic [PW-1:0]       gray_p0_q;
    logic [COL_BITS-1:0] col_p0_q;
    logic [1:0]          row_p0_q;
    logic [1:0]          mode_p0_q, gain_p0_q;
    logic [PW-1:0]       thresh_p0_q;

    // Stage 0: accept pixel, convert to gray, advance position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            gain_q      <= '0;
            thresh_q    <= '0;
            vld_p0_q    <= 1'b0;
            sof_p0_q    <= 1'b0;
            gray_p0_q   <= '0;
            col_p0_q    <= '0;
            row_p0_q    <= '0;
            mode_p0_q   <= '0;
            gain_p0_q   <= '0;
            thresh_p0_q <= '0;
        end else begin
            vld_p0_q <= in_valid;
            sof_p0_q <= in_valid & in_sof;
            if (in_valid) begin
                gray_p0_q <= gray_d;
                col_p0_q  <= pix_col;
                row_p0_q  <= pix_row;
                // The sof pixel already runs with the configuration it brings.
                mode_p0_q   <= in_sof ? mode   : mode_q;
                gain_p0_q   <= in_sof ? gain   : gain_q;
                thresh_p0_q <= in_sof ? thresh : thresh_q;
                if (in_sof) begin
                    mode_q   <= mode;
                    gain_q   <= gain;
                    thresh_q <= thresh;
                end
                col_q <= (pix_col == LAST_COL) ? '0 : pix_col + COL_BITS'(1);
                // Row saturates at 2: only "two full rows above exist" matters.
                if (pix_col == LAST_COL && pix_row != 2'd2)
                    row_q <= pix_row + 2'd1;
                else
                    row_q <= pix_row;
            end
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [PW-1:0] lb0_q [0:IMG_WIDTH-1];
    logic [PW-1:0] lb1_q [0:IMG_WIDTH-1];
    logic [PW-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0_q[col_p0_q];
    assign lb1_rd = lb1_q[col_p0_q];

    always_ff @(posedge clk) begin
        if (vld_p0_q) begin
            lb0_q[col_p0_q] <= gray_p0_q;
            lb1_q[col_p0_q] <= lb0_rd;
        end
    end

    // Window is row-major: index r*3+c, r=0 is the oldest row, c=2 the newest column.
    logic [PW-1:0] win_q [0:8];
    logic          vld_p1_q, sof_p1_q, border_p1_q;
    logic [1:0]    mode_p1_q, gain_p1_q;
    logic [PW-1:0] thresh_p1_q;

    // Stage 1: shift the window and tag incomplete windows as border.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            vld_p1_q    <= 1'b0;
            sof_p1_q    <= 1'b0;
            border_p1_q <= 1'b0;
            mode_p1_q   <= '0;
            gain_p1_q   <= '0;
            thresh_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p0_q;
            sof_p1_q <= sof_p0_q;
            if (vld_p0_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
                win_q[2]    <= lb1_rd;
                win_q[5]    <= lb0_rd;
                win_q[8]    <= gray_p0_q;
                border_p1_q <= (row_p0_q < 2'd2) || (col_p0_q < COL_BITS'(2));
                mode_p1_q   <= mode_p0_q;
                gain_p1_q   <= gain_p0_q;
                thresh_p1_q <= thresh_p0_q;
            end
        end
    end

    logic [PW-1:0] win_max, win_min, nb_max, grad0, val_d;

    always_comb begin
        win_max = win_q[0];
        win_min = win_q[0];
        nb_max  = '0;
        for (int i = 1; i < 9; i++) begin
            if (win_q[i] > win_max) win_max = win_q[i];
            if (win_q[i] < win_min) win_min = win_q[i];
        end
        for (int i = 0; i < 9; i++) begin
            if (i != 4 && abs_diff(win_q[i], win_q[4]) > nb_max)
                nb_max = abs_diff(win_q[i], win_q[4]);
        end
        grad0 = win_max - win_min;
        case (mode_p1_q)
            2'd0:    val_d = sat_gain(grad0, gain_p1_q);
            2'd1:    val_d = sat_gain(nb_max, gain_p1_q);
            2'd2:    val_d = win_q[4];
            default: val_d = (grad0 >= thresh_p1_q) ? '1 : '0;
        endcase
        if (border_p1_q) val_d = '0;
    end

    // Stage 2: registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_border <= 1'b0;
            out_pixel  <= '0;
        end else begin
            out_valid <= vld_p1_q;
            out_sof   <= sof_p1_q;
            if (vld_p1_q) begin
                out_border <= border_p1_q;
                out_pixel  <= {val_d, val_d, val_d};
            end
        end
    end
endmodule

// File: tb/tb_edge_stream_3x3.sv
module tb_edge_stream_3x3;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [11:0] in_pixel = '0;
    logic [1:0]  mode = '0;
    logic [1:0]  gain = '0;
    logic [3:0]  thresh = '0;
    logic        out_valid, out_sof, out_border;
    logic [11:0] out_pixel;

    always #5 clk = ~clk;

    edge_stream_3x3 #(.IMG_WIDTH(W), .PIX_BITS(4), .COL_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .mode(mode), .gain(gain), .thresh(thresh),
        .out_valid(out_valid), .out_sof(out_sof), .out_pixel(out_pixel),
        .out_border(out_border)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference model: the current frame as a gray image plus expectation ring.
    int          img [16][W];
    int          m_row, m_col, m_mode, m_gain, m_thr;
    bit          exp_vld [8];
    bit          exp_sof [8];
    bit          exp_bdr [8];
    logic [11:0] exp_pix [8];
    int          exp_r [8];
    int          exp_c [8];
    logic [11:0] got_pix [16][W];
    bit          got_bdr [16][W];

    function automatic int model_val(input int r, input int c);
        int v[9];
        int mx, mn, d, g;
        for (int i = 0; i < 9; i++) v[i] = img[(r - 2 + i / 3) % 16][c - 2 + i % 3];
        mx = v[0]; mn = v[0]; d = 0;
        for (int i = 0; i < 9; i++) begin
            if (v[i] > mx) mx = v[i];
            if (v[i] < mn) mn = v[i];
            if (v[i] - v[4] > d) d = v[i] - v[4];
            if (v[4] - v[i] > d) d = v[4] - v[i];
        end
        case (m_mode)
            0: g = (mx - mn) << m_gain;
            1: g = d << m_gain;
            2: g = v[4];
            default: g = ((mx - mn) >= m_thr) ? 15 : 0;
        endcase
        return (g > 15) ? 15 : g;
    endfunction

    always @(posedge clk) begin
        int slot, r, c, val;
        logic [3:0] v4;
        cyc++;
        slot = (cyc + 2) % 8;
        if (rst) begin
            m_row = 0; m_col = 0; m_mode = 0; m_gain = 0; m_thr = 0;
            for (int k = 0; k < 8; k++) exp_vld[k] = 1'b0;
        end else begin
            exp_vld[slot] = 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    m_row = 0; m_col = 0;
                    m_mode = int'(mode); m_gain = int'(gain); m_thr = int'(thresh);
                end
                r = m_row; c = m_col;
                img[r % 16][c] = (int'(in_pixel[11:8]) + int'(in_pixel[7:4]) + int'(in_pixel[3:0])) / 3;
                exp_vld[slot] = 1'b1;
                exp_sof[slot] = in_sof;
                exp_bdr[slot] = (r < 2) || (c < 2);
                val = exp_bdr[slot] ? 0 : model_val(r, c);
                v4 = 4'(val);
                exp_pix[slot] = {v4, v4, v4};
                exp_r[slot] = r; exp_c[slot] = c;
                m_col++;
                if (m_col == W) begin m_col = 0; m_row++; end
            end
        end
    end

    // Compare process: every cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        int s;
        #1;
        s = cyc % 8;
        check("out_valid", 32'(out_valid), 32'(exp_vld[s]));
        if (exp_vld[s]) begin
            check("out_sof", 32'(out_sof), 32'(exp_sof[s]));
            check("out_border", 32'(out_border), 32'(exp_bdr[s]));
            check("out_pixel", 32'(out_pixel), 32'(exp_pix[s]));
            got_pix[exp_r[s] % 16][exp_c[s]] = out_pixel;
            got_bdr[exp_r[s] % 16][exp_c[s]] = out_border;
        end
    end

    function automatic logic [11:0] pat_px(input int pat, input int r, input int c);
        logic [3:0] g;
        case (pat)
            0: return 12'h777;
            1: return (c < 4) ? 12'h000 : 12'hFFF;
            2: return (r == 2 && c == 3) ? 12'h333 : 12'h000;
            3: return (c < 4) ? 12'h444 : 12'h666;
            default: begin
                g = 4'((r * 3 + c) % 16);
                return {g, g, g};
            end
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof = 1'b0;
        end
    endtask

    task automatic send_pix(input bit sof, input logic [11:0] px);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof = sof;
        in_pixel = px;
    endtask

    // rows full rows, then extra pixels of a partial row; optional mid-frame mode change.
    task automatic send_frame(input int pat, input int rows, input int extra, input int chg_mode);
        for (int r = 0; r <= rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < rows || c < extra) begin
                    send_pix(r == 0 && c == 0, pat_px(pat, r, c));
                    if (chg_mode >= 0 && r == 1 && c == 0) mode = 2'(chg_mode);
                    if ((r * W + c) % 5 == 4) idle(1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=0 want=1");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_sof", 32'(out_sof), 32'h0);
        check("rst_out_border", 32'(out_border), 32'h0);
        check("rst_out_pixel", 32'(out_pixel), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Uniform field, mode 0.
        mode = 2'd0; gain = 2'd0;
        send_frame(0, 4, 0, -1);
        idle(4);
        check("uni_r3c5", 32'(got_pix[3][5]), 32'h000);
        check("uni_bdr_r1c4", 32'(got_bdr[1][4]), 32'h1);
        check("uni_bdr_r3c1", 32'(got_bdr[3][1]), 32'h1);
        check("uni_bdr_r2c2", 32'(got_bdr[2][2]), 32'h0);

        // Vertical step, mode 0.
        send_frame(1, 4, 0, -1);
        idle(4);
        check("step_r2c4", 32'(got_pix[2][4]), 32'hFFF);
        check("step_r3c5", 32'(got_pix[3][5]), 32'hFFF);
        check("step_r3c6", 32'(got_pix[3][6]), 32'h000);
        check("step_r2c3", 32'(got_pix[2][3]), 32'h000);

        // Single pixel, mode 1, gain 2 then 3.
        mode = 2'd1; gain = 2'd2;
        send_frame(2, 5, 0, -1);
        idle(4);
        check("dot_centre", 32'(got_pix[3][4]), 32'hCCC);
        check("dot_r2c3", 32'(got_pix[2][3]), 32'hCCC);
        check("dot_r4c5", 32'(got_pix[4][5]), 32'hCCC);
        check("dot_r3c6", 32'(got_pix[3][6]), 32'h000);
        gain = 2'd3;
        send_frame(2, 5, 0, -1);
        idle(4);
        check("dot_sat", 32'(got_pix[3][4]), 32'hFFF);

        // Threshold mode.
        mode = 2'd3; gain = 2'd0; thresh = 4'd5;
        send_frame(3, 3, 0, -1);
        idle(4);
        check("thr5_r2c4", 32'(got_pix[2][4]), 32'h000);
        thresh = 4'd2;
        send_frame(3, 3, 0, -1);
        idle(4);
        check("thr2_r2c4", 32'(got_pix[2][4]), 32'hFFF);
        check("thr2_r2c5", 32'(got_pix[2][5]), 32'hFFF);
        check("thr2_r2c3", 32'(got_pix[2][3]), 32'h000);
        check("thr2_r2c6", 32'(got_pix[2][6]), 32'h000);

        // Mode switched to 2 mid-frame, then a mid-line sof picks it up.
        mode = 2'd0; thresh = 4'd0;
        send_frame(4, 3, 3, 2);
        idle(4);
        check("chg_still_m0", 32'(got_pix[2][4]), 32'h888);
        send_frame(4, 4, 0, -1);
        idle(4);
        check("pass_r2c2", 32'(got_pix[2][2]), 32'h444);
        check("pass_r3c5", 32'(got_pix[3][5]), 32'hAAA);
        check("pass_bdr_r1c4", 32'(got_bdr[1][4]), 32'h1);

        // Reset in the middle of a row with pixels in flight.
        mode = 2'd0;
        send_frame(4, 2, 3, -1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_sof = 1'b0;
        #1;
        check("rst_drop", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        send_frame(4, 4, 0, -1);
        idle(4);
        check("post_rst_r2c4", 32'(got_pix[2][4]), 32'h888);
        check("post_rst_r3c2", 32'(got_pix[3][2]), 32'h888);
        check("post_rst_bdr", 32'(got_bdr[1][4]), 32'h1);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_stream_3x3.md
Name: edge_stream_3x3

Overview:
- Streaming successor to the combinational 3x3 edge operator; consumes RGB pixels from the camera capture path one per `in_valid` and emits one edge pixel per input.
- Builds its own 3x3 window from two internal line buffers, so the upstream no longer supplies nine taps.
- Parametrised in channel width and line length.
- Runtime-selectable operator mode, gain and threshold; sits between capture and the VGA frame buffer write port.

Parameters:
- IMG_WIDTH, 640, pixels per line (line buffer depth); min 4.
- PIX_BITS, 4, bits per colour channel; gray and gradient width.
- COL_BITS, 10, column counter width; must satisfy 2^COL_BITS >= IMG_WIDTH.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel strobe; no backpressure.
- in_sof  in  1  qualifies in_valid pixel as row 0, col 0.
- in_pixel  in  3*PIX_BITS  {R,G,B}.
- mode  in  2  0 = morphological gradient, 1 = max abs centre difference, 2 = gray passthrough, 3 = binary threshold of gradient.
- gain  in  2  left shift applied to gradient, saturating.
- thresh  in  PIX_BITS  binary threshold (mode 3).
- out_valid  out  1  output strobe.
- out_sof  out  1  marks output of the in_sof pixel.
- out_pixel  out  3*PIX_BITS  result, replicated on all three channels.
- out_border  out  1  window incomplete; out_pixel forced to 0.

Behaviour:
- Reset (async, rst=1):
  - out_valid, out_sof, out_border and out_pixel are 0.
  - Column/row counters are 0; latched mode/gain/thresh are 0.
  - Window registers are 0. Line buffer contents are don't-care.
- Stage 0 (accept, on in_valid):
  - gray = floor((R+G+B)/3), exact, PIX_BITS wide.
  - Counters: in_sof forces this pixel to col 0, row 0. Otherwise col increments; at IMG_WIDTH-1 it wraps to 0 and row increments. Row saturates at 2 (only "row>=2" matters).
  - mode/gain/thresh are latched only on an in_sof pixel, so they are frame-stable. Changes mid-frame have no effect until the next in_sof.
- Stage 1 (window):
  - Line buffer 0 holds the previous row; line buffer 1 holds the row before that. Each is read and written at address col in the same cycle (read-before-write).
  - The 3x3 window shifts left by one column per accepted pixel. The new right column is {lb1[col], lb0[col], gray}.
  - border = (row<2) or (col<2), evaluated with the stage-0 counters of the current pixel.
- Stage 2 (compute, registered):
  - Mode 0: grad = max(window) - min(window).
  - Mode 1: grad = max over the 8 neighbours of |n - centre|.
  - Mode 2: out value = window centre (gray, delayed one row + one column).
  - Mode 3: out value = all-ones if grad_mode0 >= thresh, else 0.
  - Gain: modes 0/1 output min(grad << gain, 2^PIX_BITS-1). No wrap permitted. Gain is not applied in modes 2/3.
  - If border, out value = 0 and out_border = 1.
  - out_pixel = {v,v,v}.
- Latency and sideband:
  - Exactly 3 clk from in_valid to out_valid; one output per input; gaps in in_valid propagate unchanged.
  - out_sof is in_sof delayed 3 cycles alongside out_valid.
- Boundary conditions:
  - in_sof arriving mid-line restarts counters. Border output holds for the first 2 rows of the new frame regardless of stale line buffer data.
  - Line wrap: col IMG_WIDTH-1 -> 0 in the same cycle row increments. The first 2 columns of every row are border, so the window never mixes rows.
  - rst mid-frame: pipeline valids clear immediately. Output stays border/0 until row>=2 and col>=2 after the next in_sof or reset count restart.
  - in_valid=0: no counter, buffer or window change.

Test Plan:
- IMG_WIDTH=8, uniform gray field 0x777, mode 0, 4 rows -> every output 0x000. out_border=1 for rows 0-1 and cols 0-1; out_valid exactly 3 clk after each in_valid.
- Vertical step (cols 0-3 = 0x000, cols 4-7 = 0xFFF), mode 0, gain 0 -> rows>=2: cols 4,5 output 0xFFF, cols 2,3,6,7 output 0x000. Check which columns are nonzero against the one-column window delay.
- Single centre pixel 0x333 (gray 3) on 0x000 background, mode 1, gain 2 -> its 8 neighbours' windows give grad 3<<2 = 12 = 0xCCC. Centre window also 0xCCC. gain 3 -> 24 saturates to 0xFFF.
- Mode 3, thresh 5, step of gray 4 vs 6 (e.g. 0x444 / 0x666) -> step outputs 0x000 (grad 2 < 5). thresh 2 -> 0xFFF.
- mode changed from 0 to 2 mid-frame -> no effect until next in_sof. After it, rows>=2 output equals the gray of the pixel one row up and one column left.
- rst asserted for 1 clk mid-row with in_valid toggling -> out_valid drops within the reset cycle. Next frame after in_sof: first 2 rows border, then correct gradients.
